hazard_scoreboard_unit: RTL

//  Parametrised scoreboard-based hazard unit for the 5-stage core, now supporting multi-cycle units (load, mul, div).

---
 rtl/hazard_scoreboard_unit_if.sv | 45 ++++
 rtl/hazard_scoreboard_unit.sv | 132 +++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit_if.sv
// Purpose: bundles the ID-stage request, late-redirect, writeback and
//          pipeline-control signals exchanged between the core pipeline and
//          hazard_scoreboard_unit.
// Ports (signals carried):
//   id_*           ID-stage instruction description (sources, destination, latency, branch)
//   exe_redirect   late EXE redirect squashing ID and IF
//   wb_valid/wb_rd_addr  variable-latency writeback
//   if_id_mode, id_exe_mode, if_stall, signal_cycle, stall_timeout  control outputs
// Modports: master = pipeline side, slave = hazard unit side.
interface hazard_scoreboard_unit_if #(
  parameter int ADDR_W = 5,
  parameter int LAT_W  = 3
);
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs1_addr;
  logic              id_rs1_re;
  logic [ADDR_W-1:0] id_rs2_addr;
  logic              id_rs2_re;
  logic [ADDR_W-1:0] id_rd_addr;
  logic              id_rd_we;
  logic [LAT_W-1:0]  id_lat;
  logic              id_branch;
  logic              exe_redirect;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd_addr;
  logic [1:0]        if_id_mode;
  logic [1:0]        id_exe_mode;
  logic              if_stall;
  logic              signal_cycle;
  logic              stall_timeout;

  modport master (
    output id_valid, id_rs1_addr, id_rs1_re, id_rs2_addr, id_rs2_re,
           id_rd_addr, id_rd_we, id_lat, id_branch, exe_redirect,
           wb_valid, wb_rd_addr,
    input  if_id_mode, id_exe_mode, if_stall, signal_cycle, stall_timeout
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs1_re, id_rs2_addr, id_rs2_re,
           id_rd_addr, id_rd_we, id_lat, id_branch, exe_redirect,
           wb_valid, wb_rd_addr,
    output if_id_mode, id_exe_mode, if_stall, signal_cycle, stall_timeout
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Purpose: scoreboard-based hazard unit for the 5-stage core. Tracks, per
//          GPR, either a fixed-latency countdown or a variable-latency busy
//          bit, and from that state drives IF_ID / ID_EXE stall/flush modes,
//          PC hold, taken-branch and late-redirect flushes, and a sticky
//          stall watchdog.
// Ports:
//   clk   in  core clock
//   rst   in  synchronous reset, active-high
//   bus   slave modport of hazard_scoreboard_unit_if (requests in, control out)
// Mode encoding on if_id_mode / id_exe_mode: Normal=00, Stall=01, Flush=10.
module hazard_scoreboard_unit #(
  parameter int GPR_NUM    = 32,
  parameter int ADDR_W     = 5,
  parameter int LAT_W      = 3,
  parameter int WDOG_LIMIT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  hazard_scoreboard_unit_if.slave  bus
);
  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_STALL  = 2'b01;
  localparam logic [1:0] MODE_FLUSH  = 2'b10;
  localparam int         SC_W        = $clog2(WDOG_LIMIT + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(WDOG_LIMIT);

  logic [LAT_W-1:0]   cnt_q [GPR_NUM];
  logic [LAT_W-1:0]   cnt_d [GPR_NUM];
  logic [GPR_NUM-1:0] busy_q, busy_d;
  logic [GPR_NUM-1:0] pending;
  logic [SC_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic               stall_timeout_q, stall_timeout_d;
  logic               data_haz;
  logic               issue;
  logic               issue_wr;

  // x0 is never pending, so reads of x0 can never stall.
  always_comb begin
    pending = '0;
    for (int r = 1; r < GPR_NUM; r++) begin
      pending[r] = busy_q[r] | (cnt_q[r] != '0);
    end
  end

  always_comb begin
    data_haz = bus.id_valid &&
               ((bus.id_rs1_re && (bus.id_rs1_addr != '0) && pending[bus.id_rs1_addr]) ||
                (bus.id_rs2_re && (bus.id_rs2_addr != '0) && pending[bus.id_rs2_addr]));
    issue    = bus.id_valid && !data_haz && !bus.exe_redirect;
    issue_wr = issue && bus.id_rd_we && (bus.id_rd_addr != '0);
  end

  // The counter stores the number of cycles a consumer still has to wait,
  // i.e. id_lat-1: a lat=1 producer is forwardable to the very next
  // instruction, a lat=2 producer costs exactly one bubble. An issue to rd
  // overrides both the countdown and a same-cycle writeback of rd, since the
  // new producer is the younger one.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < GPR_NUM; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : cnt_q[r];
    end
    if (bus.wb_valid && (bus.wb_rd_addr != '0)) begin
      busy_d[bus.wb_rd_addr] = 1'b0;
    end
    if (issue_wr) begin
      if (bus.id_lat != '0) begin
        cnt_d[bus.id_rd_addr]  = bus.id_lat - LAT_W'(1);
        busy_d[bus.id_rd_addr] = 1'b0;
      end else begin
        cnt_d[bus.id_rd_addr]  = '0;
        busy_d[bus.id_rd_addr] = 1'b1;
      end
    end
    cnt_d[0]  = '0;
    busy_d[0] = 1'b0;
  end

  // Watchdog: counts consecutive data-stall cycles, saturating at the limit;
  // the timeout flag is sticky until reset.
  always_comb begin
    if (!data_haz) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q == SC_MAX) begin
      stall_cnt_d = stall_cnt_q;
    end else begin
      stall_cnt_d = stall_cnt_q + SC_W'(1);
    end
    stall_timeout_d = stall_timeout_q | (stall_cnt_d == SC_MAX);
  end

  // A late redirect outranks a data stall; a branch in ID only acts when
  // its operands are ready, because otherwise it has not resolved yet.
  always_comb begin
    bus.if_id_mode   = MODE_NORMAL;
    bus.id_exe_mode  = MODE_NORMAL;
    bus.if_stall     = 1'b0;
    bus.signal_cycle = 1'b0;
    if (bus.exe_redirect) begin
      bus.if_id_mode   = MODE_FLUSH;
      bus.id_exe_mode  = MODE_FLUSH;
      bus.signal_cycle = 1'b1;
    end else if (data_haz) begin
      bus.if_id_mode   = MODE_STALL;
      bus.id_exe_mode  = MODE_FLUSH;
      bus.if_stall     = 1'b1;
      bus.signal_cycle = 1'b1;
    end else if (bus.id_branch && bus.id_valid) begin
      bus.if_id_mode   = MODE_FLUSH;
      bus.signal_cycle = 1'b1;
    end
    bus.stall_timeout = stall_timeout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < GPR_NUM; r++) begin
        cnt_q[r] <= '0;
      end
      busy_q          <= '0;
      stall_cnt_q     <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      for (int r = 0; r < GPR_NUM; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      busy_q          <= busy_d;
      stall_cnt_q     <= stall_cnt_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end
endmodule
